// File: rtl/gpu_pkg.sv
// Shared GPU core types: pipeline-stage encodings seen by the scheduler, fetcher,
// decoder, LSUs and ALUs, plus the default core geometry.
package gpu_pkg;

  localparam int DEFAULT_THREADS_PER_BLOCK = 4;
  localparam int DEFAULT_PC_WIDTH          = 8;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  // A lane still owns the memory port while it is requesting or waiting.
  function automatic logic lsu_is_busy(input logic [1:0] st);
    return (st == LSU_REQUESTING) || (st == LSU_WAITING);
  endfunction

endpackage

// File: rtl/lane_pc_select.sv
// Lowest-enabled-lane priority mux over the per-lane next-PC bus.
// With no lane enabled, lane 0 is selected.
module lane_pc_select #(
  parameter int THREADS  = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic [THREADS-1:0]          thread_enable,
  input  logic [PC_WIDTH*THREADS-1:0] next_pc,
  output logic [PC_WIDTH-1:0]         selected_pc
);

  // Scan from the top down so the lowest enabled lane is the last writer.
  always_comb begin
    selected_pc = next_pc[PC_WIDTH-1:0];
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (thread_enable[i]) begin
        selected_pc = next_pc[PC_WIDTH*i +: PC_WIDTH];
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core sequencer: walks the instruction pipeline stages, owns the core PC,
// counts retired instructions and flags kernel completion on RET.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = DEFAULT_THREADS_PER_BLOCK,
  parameter int PC_WIDTH          = DEFAULT_PC_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [THREADS_PER_BLOCK-1:0]    thread_enable,
  input  logic                            decoded_ret,
  input  logic [2:0]                      fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]  lsu_state,
  input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                      core_state,
  output logic [PC_WIDTH-1:0]             current_pc,
  output logic                            done,
  output logic [15:0]                     instr_count
);

  core_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 done_q, done_d;
  logic [15:0]          count_q, count_d;

  logic [THREADS_PER_BLOCK-1:0] lane_busy;
  logic [PC_WIDTH-1:0]          selected_pc;
  logic                         mem_busy;
  logic [15:0]                  count_inc;

  for (genvar gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
    assign lane_busy[gi] = thread_enable[gi] && lsu_is_busy(lsu_state[2*gi +: 2]);
  end

  assign mem_busy  = |lane_busy;
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  lane_pc_select #(
    .THREADS  (THREADS_PER_BLOCK),
    .PC_WIDTH (PC_WIDTH)
  ) u_lane_pc_select (
    .thread_enable (thread_enable),
    .next_pc       (next_pc),
    .selected_pc   (selected_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    count_d = count_q;
    case (state_q)
      CORE_IDLE: begin
        if (start) begin
          state_d = CORE_FETCH;
          pc_d    = '0;
          count_d = '0;
        end
      end
      CORE_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED) begin
          state_d = CORE_DECODE;
        end
      end
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (!mem_busy) begin
          state_d = CORE_EXECUTE;
        end
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        count_d = count_inc;
        if (decoded_ret) begin
          state_d = CORE_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = CORE_FETCH;
          pc_d    = selected_pc;
        end
      end
      CORE_DONE: begin
        // Terminal until reset; a new launch needs a fresh reset.
        done_d = 1'b1;
      end
      default: state_d = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CORE_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign core_state  = state_q;
  assign current_pc  = pc_q;
  assign done        = done_q;
  assign instr_count = count_q;

endmodule
